// File: rtl/status_stack.sv
// Processor status register with an interrupt/trap save stack (LIFO of status words).
// Define STATUS_STACK_OVF_EN to make a full-stack entry fault instead of overwriting the oldest entry.

package status_stack_pkg;
    typedef enum logic {
        USER       = 1'b0,
        SUPERVISOR = 1'b1
    } mode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_status_t;

    typedef struct packed {
        mode_t       mode;
        logic        imask;
        alu_status_t alu_status;
    } status_t;

    localparam status_t STATUS_RESET = '{mode: SUPERVISOR, imask: 1'b1, alu_status: '0};
endpackage

module status_stack
    import status_stack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_status_we,
    input  alu_status_t                alu_status_in,
    input  logic                       status_we,
    input  status_t                    status_in,
    input  logic                       irq,
    input  logic                       trap_req,
    input  logic                       rti_req,
    output status_t                    status_out,
    output logic                       entry_ack,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     depth_out,
    output logic                       fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        EXIT
    } state_t;

    state_t          state, state_nx;
    status_t         stack_mem [DEPTH];
    status_t         status_nx;
    logic [PW-1:0]   top, top_nx;
    logic [CW-1:0]   count, count_nx;
    logic            push_en;
    logic            fault_set;
    logic            entry_ack_nx;
    logic            full;

    assign full      = (count == CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign depth_out = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // top points one past the newest entry; it wraps modulo DEPTH so an
    // overwriting push naturally replaces the oldest slot.
    always_comb begin
        state_nx     = state;
        status_nx    = status_out;
        top_nx       = top;
        count_nx     = count;
        push_en      = 1'b0;
        fault_set    = 1'b0;
        entry_ack_nx = 1'b0;
        case (state)
            IDLE: begin
                if (rti_req) begin
                    if (count != '0) begin
                        state_nx = EXIT;
                    end else begin
                        fault_set = 1'b1;
                    end
                end else if (trap_req || (irq && !status_out.imask)) begin
                    state_nx = ENTER;
`ifdef STATUS_STACK_OVF_EN
                    if (full) begin
                        fault_set = 1'b1;
                    end else begin
                        push_en  = 1'b1;
                        top_nx   = top + 1'b1;
                        count_nx = count + 1'b1;
                    end
`else
                    push_en = 1'b1;
                    top_nx  = top + 1'b1;
                    if (!full) begin
                        count_nx = count + 1'b1;
                    end
`endif
                end else if (status_we) begin
                    if (status_out.mode == SUPERVISOR) begin
                        status_nx = status_in;
                    end else begin
                        status_nx.alu_status = status_in.alu_status;
                    end
                end else if (alu_status_we) begin
                    status_nx.alu_status = alu_status_in;
                end
            end
            ENTER: begin
                status_nx.mode  = SUPERVISOR;
                status_nx.imask = 1'b1;
                entry_ack_nx    = 1'b1;
                state_nx        = IDLE;
            end
            EXIT: begin
                status_nx = stack_mem[top - 1'b1];
                top_nx    = top - 1'b1;
                count_nx  = count - 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_out <= STATUS_RESET;
            top        <= '0;
            count      <= '0;
            fault      <= 1'b0;
            entry_ack  <= 1'b0;
        end else begin
            status_out <= status_nx;
            top        <= top_nx;
            count      <= count_nx;
            fault      <= fault | fault_set;
            entry_ack  <= entry_ack_nx;
        end
    end

    // Storage carries no reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_mem[top] <= status_out;
        end
    end

endmodule
